yutorina_bus_wdt_arbiter: RTL



---
 rtl/yutorina_bus_wdt_arbiter_if.sv | 28 ++
 rtl/yutorina_bus_wdt_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/yutorina_bus_wdt_arbiter_if.sv
// Bus-side signals of the 4-master round-robin arbiter with access watchdog.
// The arbiter takes the slave view; the masters/slave-mux side takes the master view.
interface yutorina_bus_wdt_arbiter_if;
  logic       m0_req_;
  logic       m1_req_;
  logic       m2_req_;
  logic       m3_req_;
  logic       m0_grnt_;
  logic       m1_grnt_;
  logic       m2_grnt_;
  logic       m3_grnt_;
  logic       s_as_;
  logic       m_rdy_;
  logic       bus_err;
  logic [1:0] err_owner;
  logic [7:0] err_cnt;
  logic       err_clr;

  modport slave (
    input  m0_req_, m1_req_, m2_req_, m3_req_, s_as_, m_rdy_, err_clr,
    output m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, bus_err, err_owner, err_cnt
  );

  modport master (
    output m0_req_, m1_req_, m2_req_, m3_req_, s_as_, m_rdy_, err_clr,
    input  m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, bus_err, err_owner, err_cnt
  );
endinterface

// File: rtl/yutorina_bus_wdt_arbiter.sv
// Round-robin bus arbiter (4 masters) whose watchdog revokes a grant when a slave never answers.
// States: IDLE no owner | OWN owner granted, bus quiet | WAIT access in flight | ERR watchdog fired (1 cycle)
module yutorina_bus_wdt_arbiter #(
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT   = 255
) (
  input logic                       clk,
  input logic                       rst,
  yutorina_bus_wdt_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  localparam logic [TIMEOUT_W-1:0] WDT_MAX = TIMEOUT_W'(TIMEOUT);

  logic [1:0]           state_q, state_d;
  logic [3:0]           grnt_q, grnt_d;
  logic [1:0]           owner_q, owner_d;
  logic [1:0]           last_q, last_d;
  logic [TIMEOUT_W-1:0] wdt_q, wdt_d;
  logic                 bus_err_q, bus_err_d;
  logic [1:0]           err_owner_q, err_owner_d;
  logic [7:0]           err_cnt_q, err_cnt_d;
  logic                 err_inc;

  logic [3:0] req;
  logic       owner_req;
  logic       rr_found;
  logic [1:0] rr_win;

  assign req       = ~{bus.m3_req_, bus.m2_req_, bus.m1_req_, bus.m0_req_};
  assign owner_req = req[owner_q];

  // Search starts one past the last owner, so the last owner is always checked last.
  always_comb begin
    rr_found = 1'b0;
    rr_win   = last_q;
    for (int k = 1; k <= 4; k++) begin
      if (!rr_found && req[last_q + 2'(k)]) begin
        rr_found = 1'b1;
        rr_win   = last_q + 2'(k);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grnt_d      = grnt_q;
    owner_d     = owner_q;
    last_d      = last_q;
    wdt_d       = wdt_q;
    bus_err_d   = 1'b0;
    err_owner_d = err_owner_q;
    err_inc     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        wdt_d = '0;
        if (rr_found) begin
          state_d = ST_OWN;
          grnt_d  = ~(4'b0001 << rr_win);
          owner_d = rr_win;
          last_d  = rr_win;
        end
      end
      ST_OWN: begin
        wdt_d = '0;
        if (!bus.s_as_) begin
          if (bus.m_rdy_) begin
            state_d = ST_WAIT;
            wdt_d   = TIMEOUT_W'(1);
          end
        end else if (!owner_req) begin
          // Handoff swaps grants on a single edge; owner's own req is already high.
          if (rr_found) begin
            grnt_d  = ~(4'b0001 << rr_win);
            owner_d = rr_win;
            last_d  = rr_win;
          end else begin
            state_d = ST_IDLE;
            grnt_d  = 4'hF;
          end
        end
      end
      ST_WAIT: begin
        if (!bus.m_rdy_) begin
          state_d = ST_OWN;
          wdt_d   = '0;
        end else if (wdt_q == WDT_MAX) begin
          state_d     = ST_ERR;
          grnt_d      = 4'hF;
          bus_err_d   = 1'b1;
          err_owner_d = owner_q;
          err_inc     = 1'b1;
        end else begin
          wdt_d = wdt_q + TIMEOUT_W'(1);
        end
      end
      ST_ERR: begin
        wdt_d = '0;
        if (rr_found) begin
          state_d = ST_OWN;
          grnt_d  = ~(4'b0001 << rr_win);
          owner_d = rr_win;
          last_d  = rr_win;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grnt_d  = 4'hF;
        wdt_d   = '0;
      end
    endcase
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (bus.err_clr) begin
      err_cnt_d = 8'd0;
    end else if (err_inc && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grnt_q      <= 4'hF;
      owner_q     <= 2'd0;
      last_q      <= 2'd3;
      wdt_q       <= '0;
      bus_err_q   <= 1'b0;
      err_owner_q <= 2'd0;
      err_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      grnt_q      <= grnt_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      wdt_q       <= wdt_d;
      bus_err_q   <= bus_err_d;
      err_owner_q <= err_owner_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.m0_grnt_  = grnt_q[0];
  assign bus.m1_grnt_  = grnt_q[1];
  assign bus.m2_grnt_  = grnt_q[2];
  assign bus.m3_grnt_  = grnt_q[3];
  assign bus.bus_err   = bus_err_q;
  assign bus.err_owner = err_owner_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule
